// File: rtl/wr_receiver.sv
// rtl/wr_receiver.sv - worker-result receiver: option decode, token FIFO, registered token output
// Optional statistics (TOKEN_COUNT/DROP_COUNT): define WR_RECEIVER_STATS_EN.
module wr_receiver #(
  parameter int DATA_WIDTH          = 32,
  parameter int COLOR_WIDTH         = 16,
  parameter int ADDR_WIDTH          = 10,
  parameter int OPTION_WIDTH        = 2,
  parameter int FIFO_DEPTH          = 4,
  parameter int WORKER_RESULT_WIDTH = OPTION_WIDTH + ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH,
  parameter int TOKEN_WIDTH         = 2 + ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           RECEIVE_WR_VALID,
  input  logic [WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic                           RECEIVE_WR_READY,
  output logic                           SEND_TK_VALID,
  output logic [TOKEN_WIDTH-1:0]         SEND_TK_DATA,
  input  logic                           SEND_TK_READY
`ifdef WR_RECEIVER_STATS_EN
  ,
  output logic [15:0]                    TOKEN_COUNT,
  output logic [15:0]                    DROP_COUNT
`endif
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PAYLOAD_W = ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  out_state_t             r_state;
  out_state_t             w_state_next;
  logic [TOKEN_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_next;
  logic                   r_ready;
  logic                   w_ready_next;
  logic [TOKEN_WIDTH-1:0] r_tk_data;

  logic [OPTION_WIDTH-1:0] w_opt;
  logic [PAYLOAD_W-1:0]    w_payload;
  logic                    w_port;
  logic                    w_single;
  logic                    w_discard;
  logic [TOKEN_WIDTH-1:0]  w_token;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_empty;
  logic                    w_out_xfer;

  assign w_opt     = RECEIVE_WR_DATA[WORKER_RESULT_WIDTH-1 -: OPTION_WIDTH];
  assign w_payload = RECEIVE_WR_DATA[PAYLOAD_W-1:0];

  always_comb begin
    w_port    = 1'b0;
    w_single  = 1'b0;
    w_discard = 1'b0;
    if (w_opt == OPTION_WIDTH'(1)) begin
      w_port = 1'b1;
    end else if (w_opt == OPTION_WIDTH'(2)) begin
      w_single = 1'b1;
    end else if (w_opt != OPTION_WIDTH'(0)) begin
      w_discard = 1'b1;
    end
  end

  assign w_token      = {w_port, w_single, w_payload};
  assign w_accept     = RECEIVE_WR_VALID & r_ready;
  assign w_push       = w_accept & ~w_discard;
  assign w_fifo_empty = (r_count == '0);
  assign w_out_xfer   = (r_state == OUT_FULL) & SEND_TK_READY;

  // Pops look only at the registered occupancy, so a same-edge push is never forwarded.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      OUT_EMPTY: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (w_out_xfer) begin
          if (!w_fifo_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = OUT_EMPTY;
          end
        end
      end
      default: w_state_next = OUT_EMPTY;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  assign w_ready_next = (w_count_next < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= OUT_EMPTY;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_tk_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_ready <= w_ready_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_tk_data <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && w_push) begin
      r_mem[r_wr_ptr] <= w_token;
    end
  end

  assign RECEIVE_WR_READY = r_ready;
  assign SEND_TK_VALID    = (r_state == OUT_FULL);
  assign SEND_TK_DATA     = r_tk_data;

`ifdef WR_RECEIVER_STATS_EN
  logic        w_drop;
  logic [15:0] r_token_count;
  logic [15:0] r_drop_count;

  assign w_drop = w_accept & w_discard;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_token_count <= 16'h0000;
      r_drop_count  <= 16'h0000;
    end else begin
      if (w_out_xfer && (r_token_count != 16'hFFFF)) begin
        r_token_count <= r_token_count + 16'd1;
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign TOKEN_COUNT = r_token_count;
  assign DROP_COUNT  = r_drop_count;
`endif

endmodule

// File: tb/tb_wr_receiver.sv
// tb/tb_wr_receiver.sv - directed self-checking bench for wr_receiver
// Counter checks are included when WR_RECEIVER_STATS_EN is defined.
module tb_wr_receiver;

  logic        clk = 1'b0;
  logic        RST;
  logic        RECEIVE_WR_VALID;
  logic [59:0] RECEIVE_WR_DATA;
  logic        RECEIVE_WR_READY;
  logic        SEND_TK_VALID;
  logic [59:0] SEND_TK_DATA;
  logic        SEND_TK_READY;
`ifdef WR_RECEIVER_STATS_EN
  logic [15:0] TOKEN_COUNT;
  logic [15:0] DROP_COUNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wr_receiver dut (
    .CLK              (clk),
    .RST              (RST),
    .RECEIVE_WR_VALID (RECEIVE_WR_VALID),
    .RECEIVE_WR_DATA  (RECEIVE_WR_DATA),
    .RECEIVE_WR_READY (RECEIVE_WR_READY),
    .SEND_TK_VALID    (SEND_TK_VALID),
    .SEND_TK_DATA     (SEND_TK_DATA),
    .SEND_TK_READY    (SEND_TK_READY)
`ifdef WR_RECEIVER_STATS_EN
    ,
    .TOKEN_COUNT      (TOKEN_COUNT),
    .DROP_COUNT       (DROP_COUNT)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [59:0] res(input logic [1:0] opt, input logic [9:0] a,
                                      input logic [15:0] c, input logic [31:0] d);
    return {opt, a, c, d};
  endfunction

  function automatic logic [59:0] tok(input logic [1:0] opt, input logic [9:0] a,
                                      input logic [15:0] c, input logic [31:0] d);
    logic p;
    logic s;
    p = (opt == 2'd1);
    s = (opt == 2'd2);
    return {p, s, a, c, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  idx;
    int  send_i;
    int  recv_i;
    int  cyc;
    logic acc;

    RST              = 1'b0;
    RECEIVE_WR_VALID = 1'b1;
    RECEIVE_WR_DATA  = res(2'd0, 10'h001, 16'h0001, 32'h1);
    SEND_TK_READY    = 1'b1;

    // reset held with VALID asserted
    repeat (3) tick();
    check("rst_ready", RECEIVE_WR_READY, 1'b0);
    check("rst_tk_valid", SEND_TK_VALID, 1'b0);
    check("rst_tk_data", SEND_TK_DATA, 60'h0);
`ifdef WR_RECEIVER_STATS_EN
    check("rst_token_count", TOKEN_COUNT, 16'h0);
    check("rst_drop_count", DROP_COUNT, 16'h0);
`endif
    RST              = 1'b1;
    RECEIVE_WR_VALID = 1'b0;
    check("rel_ready_before_edge", RECEIVE_WR_READY, 1'b0);
    tick();
    check("rel_ready_after_edge", RECEIVE_WR_READY, 1'b1);

    // single token, 2-edge latency, held one cycle
    RECEIVE_WR_VALID = 1'b1;
    RECEIVE_WR_DATA  = {2'd1, 10'h005, 16'h0003, 32'd42};
    tick();
    RECEIVE_WR_VALID = 1'b0;
    check("single_lat1_valid", SEND_TK_VALID, 1'b0);
    tick();
    check("single_valid", SEND_TK_VALID, 1'b1);
    check("single_data", SEND_TK_DATA, {1'b1, 1'b0, 10'h005, 16'h0003, 32'd42});
    tick();
    check("single_after_valid", SEND_TK_VALID, 1'b0);
`ifdef WR_RECEIVER_STATS_EN
    check("single_token_count", TOKEN_COUNT, 16'd1);
`endif

    // discard option, back-to-back
    RECEIVE_WR_VALID = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      RECEIVE_WR_DATA = res(2'd3, 10'h010, 16'h0010, 32'(i));
      check("discard_ready", RECEIVE_WR_READY, 1'b1);
      tick();
      check("discard_tk_valid", SEND_TK_VALID, 1'b0);
    end
    RECEIVE_WR_VALID = 1'b0;
    tick();
    tick();
    check("discard_tk_valid_late", SEND_TK_VALID, 1'b0);
`ifdef WR_RECEIVER_STATS_EN
    check("discard_drop_count", DROP_COUNT, 16'd3);
`endif

    // back-pressure: six offered, five absorbed
    SEND_TK_READY = 1'b0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      RECEIVE_WR_VALID = (idx < 6);
      RECEIVE_WR_DATA  = res(2'd0, 10'(idx), 16'h00A0 + 16'(idx), 32'd100 + 32'(idx));
      acc = RECEIVE_WR_VALID && RECEIVE_WR_READY;
      tick();
      if (acc) idx++;
    end
    check("bp_accepted", idx, 5);
    check("bp_ready_low", RECEIVE_WR_READY, 1'b0);
    check("bp_head_valid", SEND_TK_VALID, 1'b1);
    check("bp_head_data", SEND_TK_DATA, tok(2'd0, 10'd0, 16'h00A0, 32'd100));
    SEND_TK_READY = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      RECEIVE_WR_VALID = (idx < 6);
      RECEIVE_WR_DATA  = res(2'd0, 10'(idx), 16'h00A0 + 16'(idx), 32'd100 + 32'(idx));
      acc = RECEIVE_WR_VALID && RECEIVE_WR_READY;
      tick();
      if (acc) idx++;
      check("bp_drain_valid", SEND_TK_VALID, 1'b1);
      check("bp_drain_data", SEND_TK_DATA, tok(2'd0, 10'(k), 16'h00A0 + 16'(k), 32'd100 + 32'(k)));
    end
    RECEIVE_WR_VALID = 1'b0;
    check("bp_sixth_accepted", idx, 6);
    tick();
    check("bp_drained_valid", SEND_TK_VALID, 1'b0);
    check("bp_drained_ready", RECEIVE_WR_READY, 1'b1);

    // streaming with random downstream stalls
    send_i = 0;
    recv_i = 0;
    cyc    = 0;
    while ((recv_i < 100) && (cyc < 3000)) begin
      RECEIVE_WR_VALID = (send_i < 100);
      RECEIVE_WR_DATA  = res(2'(send_i % 3), 10'(send_i), 16'h5000 + 16'(send_i),
                             32'hC0DE0000 + 32'(send_i));
      SEND_TK_READY    = 1'($urandom_range(0, 1));
      acc = RECEIVE_WR_VALID && RECEIVE_WR_READY;
      if (SEND_TK_VALID && SEND_TK_READY) begin
        check("stream_tok", SEND_TK_DATA, tok(2'(recv_i % 3), 10'(recv_i), 16'h5000 + 16'(recv_i),
                                              32'hC0DE0000 + 32'(recv_i)));
        recv_i++;
      end
      tick();
      if (acc) send_i++;
      cyc++;
    end
    check("stream_count", recv_i, 100);
    RECEIVE_WR_VALID = 1'b0;
    SEND_TK_READY    = 1'b1;
    tick();
    tick();
    check("stream_no_dup", SEND_TK_VALID, 1'b0);
`ifdef WR_RECEIVER_STATS_EN
    check("stream_token_count", TOKEN_COUNT, 16'd107);
    check("stream_drop_count", DROP_COUNT, 16'd3);
`endif

    // reset with tokens buffered
    SEND_TK_READY = 1'b0;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      RECEIVE_WR_VALID = (idx < 3);
      RECEIVE_WR_DATA  = res(2'd0, 10'h100 + 10'(idx), 16'h0BAD, 32'(idx));
      acc = RECEIVE_WR_VALID && RECEIVE_WR_READY;
      tick();
      if (acc) idx++;
    end
    RECEIVE_WR_VALID = 1'b0;
    check("mid_buffered", SEND_TK_VALID, 1'b1);
    RST = 1'b0;
    tick();
    check("mid_rst_ready", RECEIVE_WR_READY, 1'b0);
    check("mid_rst_valid", SEND_TK_VALID, 1'b0);
    check("mid_rst_data", SEND_TK_DATA, 60'h0);
`ifdef WR_RECEIVER_STATS_EN
    check("mid_rst_token_count", TOKEN_COUNT, 16'h0);
`endif
    RST = 1'b1;
    tick();
    check("mid_rel_ready", RECEIVE_WR_READY, 1'b1);
    SEND_TK_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_no_stale", SEND_TK_VALID, 1'b0);
    end
    RECEIVE_WR_VALID = 1'b1;
    RECEIVE_WR_DATA  = {2'd2, 10'h3FF, 16'hFFFF, 32'hDEADBEEF};
    tick();
    RECEIVE_WR_VALID = 1'b0;
    check("mid_lat1_valid", SEND_TK_VALID, 1'b0);
    tick();
    check("mid_lat2_valid", SEND_TK_VALID, 1'b1);
    check("mid_lat2_data", SEND_TK_DATA, {1'b0, 1'b1, 10'h3FF, 16'hFFFF, 32'hDEADBEEF});
    tick();
    check("mid_done_valid", SEND_TK_VALID, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
